// File: rtl/decryption_cycle_profiler.sv
// Multi-channel start/done cycle profiler: per-channel timestamp capture and
// duration measurement, with completed records queued in a valid/ready FIFO.
module decryption_cycle_profiler #(
  parameter int NCH   = 5,
  parameter int CNT_W = 32,
  parameter int DEPTH = 8,
  parameter int CH_W  = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clear,
  input  logic [NCH-1:0]          start_i,
  input  logic [NCH-1:0]          done_i,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [CH_W+2*CNT_W-1:0] out_data,
  output logic [NCH-1:0]          busy_o,
  output logic [NCH-1:0]          overflow_o,
  output logic [NCH-1:0]          orphan_o
);

  localparam int AW    = $clog2(DEPTH);
  localparam int REC_W = CH_W + 2*CNT_W;

  logic [CNT_W-1:0] ts_q, ts_d;
  logic [NCH-1:0]   start_prev_q, start_prev_d;
  logic [NCH-1:0]   done_prev_q, done_prev_d;
  logic [NCH-1:0]   busy_q, busy_d;
  logic [NCH-1:0]   pend_q, pend_d;
  logic [NCH-1:0]   ovf_q, ovf_d;
  logic [NCH-1:0]   orph_q, orph_d;
  logic [CNT_W-1:0] start_ts_q [NCH];
  logic [CNT_W-1:0] start_ts_d [NCH];
  logic [CNT_W-1:0] pend_ts_q  [NCH];
  logic [CNT_W-1:0] pend_ts_d  [NCH];
  logic [CNT_W-1:0] pend_dur_q [NCH];
  logic [CNT_W-1:0] pend_dur_d [NCH];

  logic [REC_W-1:0] mem_q [DEPTH];
  logic [REC_W-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;

  logic [NCH-1:0]   start_edge_s, done_edge_s;
  logic [NCH-1:0]   push_oh_s;
  logic             push_s, pop_s, full_s;
  logic [REC_W-1:0] push_rec_s;

  assign start_edge_s = start_i & ~start_prev_q;
  assign done_edge_s  = done_i & ~done_prev_q;
  assign full_s       = (count_q == (AW+1)'(DEPTH));
  assign pop_s        = (count_q != '0) && out_ready;

  // Arbiter: lowest-index pending channel wins the single push slot.
  always_comb begin
    push_s     = 1'b0;
    push_oh_s  = '0;
    push_rec_s = '0;
    if (!full_s) begin
      for (int i = 0; i < NCH; i++) begin
        if (pend_q[i] && !push_s) begin
          push_s       = 1'b1;
          push_oh_s[i] = 1'b1;
          push_rec_s   = {CH_W'(i), pend_ts_q[i], pend_dur_q[i]};
        end
      end
    end
  end

  // Channel state: done is resolved against the old start_ts before a same-cycle start.
  always_comb begin
    ts_d         = ts_q + CNT_W'(1);
    start_prev_d = start_i;
    done_prev_d  = done_i;
    busy_d       = busy_q;
    pend_d       = pend_q & ~push_oh_s;
    ovf_d        = ovf_q;
    orph_d       = orph_q;
    start_ts_d   = start_ts_q;
    pend_ts_d    = pend_ts_q;
    pend_dur_d   = pend_dur_q;
    for (int i = 0; i < NCH; i++) begin
      if (done_edge_s[i]) begin
        if (busy_q[i]) begin
          busy_d[i] = 1'b0;
          if (pend_q[i]) begin
            ovf_d[i] = 1'b1;
          end else begin
            pend_d[i]     = 1'b1;
            pend_ts_d[i]  = start_ts_q[i];
            pend_dur_d[i] = ts_q - start_ts_q[i];
          end
        end else begin
          orph_d[i] = 1'b1;
        end
      end
      if (start_edge_s[i]) begin
        busy_d[i]     = 1'b1;
        start_ts_d[i] = ts_q;
      end
    end
  end

  // FIFO pointers, count and storage.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q + AW'(push_s);
    rd_ptr_d = rd_ptr_q + AW'(pop_s);
    count_d  = count_q + (AW+1)'(push_s) - (AW+1)'(pop_s);
    if (push_s) begin
      mem_d[wr_ptr_q] = push_rec_s;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ts_q         <= '0;
      start_prev_q <= '0;
      done_prev_q  <= '0;
      busy_q       <= '0;
      pend_q       <= '0;
      ovf_q        <= '0;
      orph_q       <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      for (int i = 0; i < NCH; i++) begin
        start_ts_q[i] <= '0;
        pend_ts_q[i]  <= '0;
        pend_dur_q[i] <= '0;
      end
      for (int j = 0; j < DEPTH; j++) begin
        mem_q[j] <= '0;
      end
    end else if (clear) begin
      ts_q         <= '0;
      start_prev_q <= '0;
      done_prev_q  <= '0;
      busy_q       <= '0;
      pend_q       <= '0;
      ovf_q        <= '0;
      orph_q       <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      for (int i = 0; i < NCH; i++) begin
        start_ts_q[i] <= '0;
        pend_ts_q[i]  <= '0;
        pend_dur_q[i] <= '0;
      end
      for (int j = 0; j < DEPTH; j++) begin
        mem_q[j] <= '0;
      end
    end else begin
      ts_q         <= ts_d;
      start_prev_q <= start_prev_d;
      done_prev_q  <= done_prev_d;
      busy_q       <= busy_d;
      pend_q       <= pend_d;
      ovf_q        <= ovf_d;
      orph_q       <= orph_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      start_ts_q   <= start_ts_d;
      pend_ts_q    <= pend_ts_d;
      pend_dur_q   <= pend_dur_d;
      mem_q        <= mem_d;
    end
  end

  // Head record is read straight from storage so the consumer sees it with no extra latency.
  assign out_valid  = (count_q != '0);
  assign out_data   = mem_q[rd_ptr_q];
  assign busy_o     = busy_q;
  assign overflow_o = ovf_q;
  assign orphan_o   = orph_q;

endmodule

// File: tb/tb_decryption_cycle_profiler.sv
// Directed self-checking bench for decryption_cycle_profiler (10 channels, 8-bit timestamps).
module tb_decryption_cycle_profiler;

  localparam int NCH   = 10;
  localparam int CNT_W = 8;
  localparam int DEPTH = 8;
  localparam int CH_W  = 4;
  localparam int DW    = CH_W + 2*CNT_W;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           clear;
  logic [NCH-1:0] start_i;
  logic [NCH-1:0] done_i;
  logic           out_valid;
  logic           out_ready;
  logic [DW-1:0]  out_data;
  logic [NCH-1:0] busy_o;
  logic [NCH-1:0] overflow_o;
  logic [NCH-1:0] orphan_o;

  int checks = 0;
  int errors = 0;
  int t = 0;

  decryption_cycle_profiler #(
    .NCH(NCH), .CNT_W(CNT_W), .DEPTH(DEPTH), .CH_W(CH_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .start_i(start_i), .done_i(done_i),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy_o(busy_o), .overflow_o(overflow_o), .orphan_o(orphan_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] rec(input int ch, input int st, input int du);
    return {CH_W'(ch), CNT_W'(st), CNT_W'(du)};
  endfunction

  // t mirrors the timestamp the DUT holds between edges
  task automatic tick();
    @(posedge clk);
    #1;
    t++;
  endtask

  task automatic go_to(input int n);
    while (t < n) tick();
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    t = 0;
  endtask

  int exp_ch  [9] = '{0, 1, 3, 4, 5, 6, 7, 8, 2};
  int exp_dur [9] = '{10, 10, 10, 10, 10, 10, 10, 10, 20};

  initial begin
    rst_n = 1'b0; clear = 1'b0; start_i = '0; done_i = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_data", 64'(out_data), 64'd0);
    check("rst_busy", 64'(busy_o), 64'd0);
    check("rst_flags", 64'({overflow_o, orphan_o}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // single channel: start ts=3, done ts=10
    do_clear();
    go_to(3);
    check("s1_busy_pre", 64'(busy_o), 64'd0);
    start_i = 10'h001;
    tick();
    check("s1_busy_t4", 64'(busy_o), 64'h001);
    start_i = '0;
    go_to(10);
    check("s1_busy_t10", 64'(busy_o), 64'h001);
    done_i = 10'h001;
    tick();
    check("s1_busy_after", 64'(busy_o), 64'd0);
    check("s1_valid_E", 64'(out_valid), 64'd0);
    done_i = '0;
    tick();
    check("s1_valid_E1", 64'(out_valid), 64'd1);
    check("s1_data", 64'(out_data), 64'(rec(0, 3, 7)));
    out_ready = 1'b1;
    tick();
    check("s1_empty", 64'(out_valid), 64'd0);
    out_ready = 1'b0;

    // simultaneous done on ch1 and ch3
    do_clear();
    start_i = 10'h00A;
    tick();
    start_i = '0;
    go_to(5);
    out_ready = 1'b1;
    done_i = 10'h00A;
    tick();
    check("s2_valid_E", 64'(out_valid), 64'd0);
    done_i = '0;
    tick();
    check("s2_valid1", 64'(out_valid), 64'd1);
    check("s2_rec_ch1", 64'(out_data), 64'(rec(1, 0, 5)));
    tick();
    check("s2_valid2", 64'(out_valid), 64'd1);
    check("s2_rec_ch3", 64'(out_data), 64'(rec(3, 0, 5)));
    tick();
    check("s2_empty", 64'(out_valid), 64'd0);
    out_ready = 1'b0;

    // FIFO full: eight completions queue, ch2 held pending, then ch2 overflow
    do_clear();
    start_i = 10'h1FF;
    tick();
    start_i = '0;
    go_to(10);
    done_i = 10'h1FB;
    tick();
    done_i = '0;
    go_to(20);
    check("s3_head", 64'(out_data), 64'(rec(0, 0, 10)));
    done_i = 10'h004;
    tick();
    done_i = '0;
    repeat (3) tick();
    check("s3_valid", 64'(out_valid), 64'd1);
    check("s3_no_ovf", 64'(overflow_o), 64'd0);
    check("s3_busy", 64'(busy_o), 64'd0);
    start_i = 10'h004;
    tick();
    start_i = '0;
    go_to(30);
    done_i = 10'h004;
    tick();
    done_i = '0;
    check("s4_ovf", 64'(overflow_o), 64'h004);
    check("s4_orphan", 64'(orphan_o), 64'd0);
    out_ready = 1'b1;
    for (int k = 0; k < 9; k++) begin
      check($sformatf("s3_drain_valid%0d", k), 64'(out_valid), 64'd1);
      check($sformatf("s3_drain_rec%0d", k), 64'(out_data), 64'(rec(exp_ch[k], 0, exp_dur[k])));
      tick();
    end
    check("s3_drained", 64'(out_valid), 64'd0);
    tick();
    check("s4_single_ch2", 64'(out_valid), 64'd0);
    out_ready = 1'b0;

    // orphan on ch4 and restart on ch0
    do_clear();
    check("s5_clear_flags", 64'({overflow_o, orphan_o}), 64'd0);
    go_to(5);
    start_i = 10'h001;
    tick();
    start_i = '0;
    go_to(7);
    done_i = 10'h010;
    tick();
    done_i = '0;
    check("s5_orphan", 64'(orphan_o), 64'h010);
    go_to(9);
    start_i = 10'h001;
    tick();
    start_i = '0;
    go_to(20);
    done_i = 10'h001;
    tick();
    done_i = '0;
    tick();
    check("s5_valid", 64'(out_valid), 64'd1);
    check("s5_rec", 64'(out_data), 64'(rec(0, 9, 11)));
    out_ready = 1'b1;
    tick();
    check("s5_no_ch4", 64'(out_valid), 64'd0);
    out_ready = 1'b0;

    // timestamp wrap: start at 250, done at 4 after wrap
    do_clear();
    go_to(250);
    start_i = 10'h001;
    tick();
    start_i = '0;
    go_to(260);
    done_i = 10'h001;
    tick();
    done_i = '0;
    tick();
    check("s6_wrap_valid", 64'(out_valid), 64'd1);
    check("s6_wrap_rec", 64'(out_data), 64'(rec(0, 250, 10)));

    // asynchronous reset mid-measurement
    start_i = 10'h002;
    tick();
    start_i = '0;
    done_i = 10'h020;
    tick();
    done_i = '0;
    check("s6_pre_busy", 64'(busy_o), 64'h002);
    check("s6_pre_orphan", 64'(orphan_o), 64'h020);
    #2;
    rst_n = 1'b0;
    #1;
    check("s6_rst_valid", 64'(out_valid), 64'd0);
    check("s6_rst_data", 64'(out_data), 64'd0);
    check("s6_rst_busy", 64'(busy_o), 64'd0);
    check("s6_rst_flags", 64'({overflow_o, orphan_o}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    t = 0;
    start_i = 10'h001;
    tick();
    start_i = '0;
    go_to(6);
    done_i = 10'h001;
    tick();
    done_i = '0;
    tick();
    check("s6_post_valid", 64'(out_valid), 64'd1);
    check("s6_post_rec", 64'(out_data), 64'(rec(0, 0, 6)));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
